// File: rtl/md5_pkg.sv
// md5_pkg: block geometry and loader state encodings shared by the MD5 loader, padding and top sequencers.
package md5_pkg;
  localparam int BLOCK_BYTES = 64;
  localparam int BLOCK_BITS = 512;
  typedef enum logic [1:0] {ST_INIT, ST_FILL, ST_HOLD} ld_state_e;
  function automatic logic [8:0] byte_lsb(input logic [5:0] idx);
    return {idx, 3'b000};
  endfunction
endpackage

// File: rtl/md5_block_loader_if.sv
// md5_block_loader_if: byte-stream input and 512-bit block output of the MD5 block loader.
interface md5_block_loader_if import md5_pkg::*; #(parameter int SIZE_W = 64);
  logic in_valid;
  logic [7:0] in_data;
  logic in_last;
  logic in_empty;
  logic in_ready;
  logic blk_valid;
  logic [0:BLOCK_BITS-1] blk_data;
  logic blk_last;
  logic [6:0] blk_bytes;
  logic [SIZE_W-1:0] msg_bits;
  logic blk_ready;
  modport master (
    output in_valid, in_data, in_last, in_empty, blk_ready,
    input in_ready, blk_valid, blk_data, blk_last, blk_bytes, msg_bits
  );
  modport slave (
    input in_valid, in_data, in_last, in_empty, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last, blk_bytes, msg_bits
  );
endinterface

// File: rtl/md5_block_loader.sv
// md5_block_loader: packs a byte stream into 64-byte MD5 blocks and tracks the message bit length.
// Optional MD5_LOADER_ABORT_EN adds an abort input that discards the message in progress.
module md5_block_loader import md5_pkg::*; #(
  parameter int SIZE_W = 64
) (
  input logic clk,
  input logic rst_n,
`ifdef MD5_LOADER_ABORT_EN
  input logic abort,
`endif
  md5_block_loader_if.slave bus
);
  ld_state_e state_q, state_d;
  logic [0:BLOCK_BITS-1] data_q, data_d;
  logic [6:0] cnt_q, cnt_d;
  logic [SIZE_W-4:0] msg_q, msg_d;
  logic last_q, last_d;
  logic accept, take_byte, close;
  assign accept = bus.in_valid && state_q == ST_FILL;
  assign take_byte = accept && !bus.in_empty;
  // empty without last is a no-op; empty with last only closes the block
  assign close = accept && (bus.in_last || (take_byte && cnt_q == 7'(BLOCK_BYTES - 1)));
  always_comb begin
    state_d = state_q == ST_INIT ? ST_FILL : state_q;
    data_d = data_q;
    cnt_d = cnt_q;
    msg_d = msg_q;
    last_d = last_q;
    if (take_byte) begin
      data_d[byte_lsb(cnt_q[5:0]) +: 8] = bus.in_data;
      cnt_d = cnt_q + 7'd1;
      msg_d = msg_q + {{(SIZE_W-4){1'b0}}, 1'b1};
    end
    if (close) begin
      state_d = ST_HOLD;
      last_d = bus.in_last;
    end
    if (state_q == ST_HOLD && bus.blk_ready) begin
      state_d = ST_FILL;
      data_d = '0;
      cnt_d = '0;
      msg_d = last_q ? '0 : msg_q;
      last_d = 1'b0;
    end
`ifdef MD5_LOADER_ABORT_EN
    if (abort) begin
      state_d = ST_FILL;
      data_d = '0;
      cnt_d = '0;
      msg_d = '0;
      last_d = 1'b0;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      data_q <= '0;
      cnt_q <= '0;
      msg_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      msg_q <= msg_d;
      last_q <= last_d;
    end
  end
  assign bus.in_ready = state_q == ST_FILL;
  assign bus.blk_valid = state_q == ST_HOLD;
  assign bus.blk_data = data_q;
  assign bus.blk_last = last_q;
  assign bus.blk_bytes = cnt_q;
  assign bus.msg_bits = {msg_q, 3'b000};
endmodule

// File: tb/tb_md5_block_loader.sv
// tb_md5_block_loader: table-driven messages checked through a block scoreboard, plus stall/reset/abort sequences.
module tb_md5_block_loader;
  import md5_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef MD5_LOADER_ABORT_EN
  logic abort = 1'b0;
`endif
  md5_block_loader_if #(.SIZE_W(64)) bus();
  md5_block_loader #(.SIZE_W(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MD5_LOADER_ABORT_EN
    .abort(abort),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [0:511] data;
    int bytes;
    bit last;
    logic [63:0] bits;
  } blk_t;
  typedef struct {
    string name;
    string txt;
    int len;
    bit empty_end;
    int nblk;
    int last_bytes;
    logic [63:0] bits;
  } vec_t;

  blk_t sb_q[$];
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  bit rnd_rdy = 1'b0;
  bit man_rdy = 1'b0;
  logic [0:511] softex_blk;
  assign bus.blk_ready = mon_en ? rnd_rdy : man_rdy;

  task automatic chk(string n, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, got, want);
    end
  endtask

  task automatic chk_blk(string n, logic [0:511] got, logic [0:511] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  function automatic vec_t mk(string n, string t, int len, bit ee, int nb, int lb, logic [63:0] bits);
    vec_t v;
    v.name = n; v.txt = t; v.len = len; v.empty_end = ee;
    v.nblk = nb; v.last_bytes = lb; v.bits = bits;
    return v;
  endfunction

  // call at a negedge; returns at the negedge after the accepting edge
  task automatic send(logic [7:0] d, bit l, bit e);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l; bus.in_empty = e;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stayed %0b want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(s[i], i == s.len() - 1, 1'b0);
  endtask

  task automatic wait_blk(string n);
    int k = 0;
    while (!bus.blk_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      total++; bad++;
      $display("FAIL %s_timeout: blk_valid %0b want 1", n, bus.blk_valid);
    end
  endtask

  task automatic handshake();
    man_rdy = 1'b1;
    @(negedge clk);
    man_rdy = 1'b0;
  endtask

  task automatic check_softex(string n);
    wait_blk(n);
    chk_blk({n, "_data"}, bus.blk_data, softex_blk);
    chk({n, "_bytes"}, 64'(bus.blk_bytes), 64'd6);
    chk({n, "_last"}, 64'(bus.blk_last), 64'd1);
    chk({n, "_bits"}, bus.msg_bits, 64'h30);
  endtask

  // scoreboard monitor: random downstream backpressure, pops on each handshake
  initial begin
    logic [0:511] s_d;
    logic [6:0] s_b;
    logic s_l;
    logic [63:0] s_m;
    bit hold;
    blk_t e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        total++;
        if (!(bus.blk_valid && bus.blk_data === s_d && bus.blk_bytes === s_b && bus.blk_last === s_l && bus.msg_bits === s_m)) begin
          bad++;
          $display("FAIL hold_stable: valid=%0b bytes=%0d last=%0b bits=%0h want valid=1 bytes=%0d last=%0b bits=%0h",
                   bus.blk_valid, bus.blk_bytes, bus.blk_last, bus.msg_bits, s_b, s_l, s_m);
        end
      end
      rnd_rdy = $urandom_range(0, 3) != 0;
      if (bus.blk_valid && rnd_rdy) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_blk: got bytes=%0d want no block", bus.blk_bytes);
        end else begin
          e = sb_q.pop_front();
          chk_blk("blk_data", bus.blk_data, e.data);
          chk("blk_bytes", 64'(bus.blk_bytes), 64'(e.bytes));
          chk("blk_last", 64'(bus.blk_last), 64'(e.last));
          if (e.last) chk("msg_bits", bus.msg_bits, e.bits);
        end
      end
      hold = bus.blk_valid && !rnd_rdy;
      s_d = bus.blk_data; s_b = bus.blk_bytes; s_l = bus.blk_last; s_m = bus.msg_bits;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v[7];
    logic [7:0] m[];
    blk_t e;
    int n, cnt;
    string lorem;
    lorem = "Lorem ipsum dolor sit amet, consectetur adipiscing elit, sed do eiusmod tempor incididunt ut labore et dolore magna aliqua. ";
    softex_blk = {"Softex", 464'b0};
    v[0] = mk("softex", "Softex", 6, 1'b0, 1, 6, 64'h30);
    v[1] = mk("lorem190", lorem, 190, 1'b0, 3, 62, 64'h5F0);
    v[2] = mk("exact64", "", 64, 1'b0, 1, 64, 64'h200);
    v[3] = mk("zero_len", "", 0, 1'b1, 1, 0, 64'h0);
    v[4] = mk("b128_empty", "", 128, 1'b1, 3, 0, 64'h400);
    v[5] = mk("b65", "", 65, 1'b0, 2, 1, 64'h208);
    v[6] = mk("b10_empty", "", 10, 1'b1, 1, 10, 64'h50);
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0; bus.in_empty = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_blk_valid", 64'(bus.blk_valid), 64'd0);
    chk_blk("rst_blk_data", bus.blk_data, '0);
    chk("rst_blk_last", 64'(bus.blk_last), 64'd0);
    chk("rst_blk_bytes", 64'(bus.blk_bytes), 64'd0);
    chk("rst_msg_bits", bus.msg_bits, 64'd0);
    rst_n = 1'b1;
    #1 chk("init_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    chk("fill_in_ready", 64'(bus.in_ready), 64'd1);

    mon_en = 1'b1;
    for (int t = 0; t < 7; t++) begin
      m = new[v[t].len];
      for (int i = 0; i < v[t].len; i++)
        m[i] = v[t].txt.len() != 0 ? v[t].txt[i % v[t].txt.len()] : 8'((i * 37 + 5 + t) & 255);
      for (int k = 0; k < v[t].nblk; k++) begin
        cnt = k == v[t].nblk - 1 ? v[t].last_bytes : 64;
        e.data = '0;
        for (int j = 0; j < cnt; j++) e.data[j*8 +: 8] = m[k*64 + j];
        e.bytes = cnt;
        e.last = k == v[t].nblk - 1;
        e.bits = v[t].bits;
        sb_q.push_back(e);
      end
      for (int i = 0; i < v[t].len; i++) begin
        if ($urandom_range(0, 7) == 0) send(8'hEE, 1'b0, 1'b1);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send(m[i], i == v[t].len - 1 && !v[t].empty_end, 1'b0);
      end
      if (v[t].empty_end) send(8'h5A, 1'b1, 1'b1);
    end
    n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    man_rdy = 1'b0;
    @(negedge clk);

    send_str("Softex");
    check_softex("stall0");
    bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.in_last = 1'b1; bus.in_empty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_valid", 64'(bus.blk_valid), 64'd1);
      chk_blk("stall_data", bus.blk_data, softex_blk);
      chk("stall_bytes", 64'(bus.blk_bytes), 64'd6);
      chk("stall_bits", bus.msg_bits, 64'h30);
      @(negedge clk);
    end
    handshake();
    chk("post_hs_valid", 64'(bus.blk_valid), 64'd0);
    chk("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_hs_bytes", 64'(bus.blk_bytes), 64'd0);
    chk("post_hs_bits", bus.msg_bits, 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_blk("one_byte_data", bus.blk_data, {8'hAA, 504'b0});
    chk("one_byte_bytes", 64'(bus.blk_bytes), 64'd1);
    chk("one_byte_bits", bus.msg_bits, 64'd8);
    handshake();

    for (int i = 0; i < 30; i++) send(8'(i + 1), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk_blk("mid_rst_data", bus.blk_data, '0);
    chk("mid_rst_bytes", 64'(bus.blk_bytes), 64'd0);
    chk("mid_rst_bits", bus.msg_bits, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_init_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    chk("rel_fill_in_ready", 64'(bus.in_ready), 64'd1);
    send_str("Softex");
    check_softex("after_rst");
    handshake();

`ifdef MD5_LOADER_ABORT_EN
    for (int i = 0; i < 20; i++) send(8'(i + 100), 1'b0, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.in_last = 1'b0; bus.in_empty = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_bytes", 64'(bus.blk_bytes), 64'd0);
    chk("abort_bits", bus.msg_bits, 64'd0);
    send_str("Softex");
    check_softex("after_abort");
    handshake();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md5_block_loader.md
MD5_BLOCK_LOADER -- requirements
Module: md5_block_loader

Interface
REQ-001 Parameter SIZE_W, default 64, width of the message-length output in bits.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  upstream byte/end strobe valid.
REQ-005 in_data  input  8  message byte; first byte of the message lands in blk_data[0:7].
REQ-006 in_last  input  1  qualifies in_valid: this transfer ends the message.
REQ-007 in_empty  input  1  qualifies in_valid with in_last=1: transfer carries no byte; in_data is ignored.
REQ-008 in_ready  output  1  loader accepts a transfer this cycle.
REQ-009 blk_valid  output  1  assembled block available.
REQ-010 blk_data  output  [0:511]  block bytes in arrival order; unfilled bytes are zero.
REQ-011 blk_last  output  1  block holds the final byte(s) of the message.
REQ-012 blk_bytes  output  7  valid byte count in blk_data (0..64).
REQ-013 msg_bits  output  SIZE_W  total message length in bits; valid when blk_valid and blk_last are both 1.
REQ-014 blk_ready  input  1  downstream (padding/core sequencer) consumes the block.

Function
REQ-015 The FSM SHALL use states INIT, FILL and HOLD: INIT->FILL unconditionally; FILL->HOLD on an accepted transfer that fills byte 64 or has in_last=1; HOLD->FILL on blk_valid&&blk_ready.
REQ-016 in_ready SHALL be 1 only in FILL; a transfer is accepted when in_valid&&in_ready.
REQ-017 An accepted byte SHALL be written to byte slot byte_cnt, and byte_cnt incremented; byte_cnt SHALL be 0..64.
REQ-018 blk_valid SHALL be 1 exactly in HOLD, i.e. one cycle after the accepting edge; blk_data, blk_last, blk_bytes and msg_bits SHALL be stable while blk_valid=1 and blk_ready=0.
REQ-019 On the 64th byte with in_last=0, blk_last SHALL be 0; with in_last=1, blk_last SHALL be 1 and blk_bytes SHALL be 64.
REQ-020 An in_empty transfer SHALL add no byte; with byte_cnt=0 it SHALL yield a block with blk_bytes=0 and blk_data all zero (zero-length message); with byte_cnt>0 it SHALL only close the current block.
REQ-021 in_empty without in_last SHALL be ignored and accepted as a no-op.
REQ-022 The byte counter for the message SHALL count modulo 2^(SIZE_W-3); msg_bits = bytes*8 SHALL wrap modulo 2^SIZE_W (MD5 length rule).
REQ-023 On the HOLD->FILL handshake, blk_data and byte_cnt SHALL clear; the message counter SHALL clear only if blk_last was 1.
REQ-024 Throughput: one idle (HOLD) cycle minimum per 64-byte block; no transfer is accepted in HOLD.

Reset
REQ-025 While rst_n=0: state INIT, in_ready 0, blk_valid 0, blk_data 0, blk_last 0, blk_bytes 0, msg_bits 0, all counters 0.
REQ-026 Reset asserted mid-message or in HOLD SHALL discard all partial data; the first cycle after release is INIT (in_ready 0), then FILL.

Configuration
REQ-027 With MD5_LOADER_ABORT_EN defined, input abort (1 bit) SHALL exist; abort=1 in any state SHALL, on that edge, clear buffer and counters, drop blk_valid and enter FILL; abort SHALL win over a simultaneous accept or block handshake.
REQ-028 Without MD5_LOADER_ABORT_EN, the abort port SHALL be absent and behaviour is REQ-015..REQ-026 only.

Structure
REQ-029 State encodings, BLOCK_BYTES=64 and BLOCK_BITS=512 SHALL live in shared package md5_pkg, reused by the padding and top sequencers.
REQ-030 No sub-module; the loader is a single module.

Verification
REQ-031 "Softex" (6 bytes, last on byte 6) -> one block, blk_data={"Softex",464'b0}, blk_bytes=6, blk_last=1, msg_bits=0x30.
REQ-032 190-byte Lorem ipsum text -> three blocks, blk_bytes 64/64/62, blk_last 0/0/1, msg_bits=0x5F0 on block 3.
REQ-033 Exactly 64 bytes, last on byte 64 -> one block, blk_bytes=64, blk_last=1, msg_bits=0x200; zero-length (in_empty+in_last) -> blk_bytes=0, blk_data=0, msg_bits=0.
REQ-034 blk_ready held 0 for 10 cycles in HOLD -> in_ready=0, outputs unchanged all 10 cycles; handshake -> FILL next cycle with byte_cnt=0.
REQ-035 rst_n pulsed low after 30 bytes -> all outputs 0; after release, INIT then FILL; new 6-byte message gives msg_bits=0x30.
REQ-036 (MD5_LOADER_ABORT_EN) abort with in_valid=1 after 20 bytes -> byte not taken, next message "Softex" gives msg_bits=0x30.
